prime_tester: RTL
=================

PRIME_TESTER -- requirements
Module: prime_tester

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning candidate bit width (even, >= 4).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled only when accepting (IDLE or DONE).
REQ-005 SHALL have port num  input  WIDTH  candidate, captured on the edge that accepts start.
REQ-006 SHALL have port busy  output  1  high in every state except IDLE and DONE.
REQ-007 SHALL have port finish  output  1  one-cycle pulse, high exactly while in DONE.
REQ-008 SHALL have port is_prime  output  1  result, valid from finish, held until next accepted start.
REQ-009 SHALL have port factor  output  WIDTH  smallest nontrivial divisor; 0 if prime or num < 2.

Function
REQ-010 SHALL implement FSM IDLE -> CHECK -> (DIV -> NEXT)* -> DONE -> IDLE.
REQ-011 Accepting start (edge T) SHALL latch num, clear is_prime/factor to 0, enter CHECK at T+1.
REQ-012 start while busy SHALL be ignored, with no effect on state or outputs.
REQ-013 CHECK SHALL classify: num<2 -> not prime, factor 0; num 2 or 3 -> prime; even num>2 -> factor 2.
REQ-014 Otherwise trial divisor d SHALL start at 3 and step by 2; d and d*d carried at WIDTH/2+1 and WIDTH+2 bits, no overflow.
REQ-015 DIV SHALL compute num mod d in exactly WIDTH cycles (restoring, one quotient bit per cycle).
REQ-016 NEXT (1 cycle) SHALL record d as factor if remainder==0, d*d<=num and no factor recorded yet.
REQ-017 Loop SHALL end (-> DONE) when a factor is recorded or the next d has d*d>num; is_prime=1 iff no factor and num>=2.
REQ-018 Trivial cases and num with 9>num SHALL reach DONE at T+2 (finish high in cycle after CHECK).
REQ-019 DONE SHALL last one cycle and then return to IDLE; start during DONE SHALL be accepted as in IDLE.
REQ-020 Variable-mode latency SHALL be 2 + k*(WIDTH+1) cycles, k = divisors tried.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, busy=0, finish=0, is_prime=0, factor=0, d and datapath cleared.
REQ-022 Reset mid-operation SHALL abandon the computation; no finish pulse SHALL follow reset release.

Configuration
REQ-023 Macro PRIME_TESTER_CONST_TIME_EN SHALL select constant-time mode when defined.
REQ-024 Defined: CHECK never exits early; every odd d in [3, 2^(WIDTH/2)-1] SHALL be tried; REQ-016 gates recording; latency fixed at 2 + (2^(WIDTH/2-1)-1)*(WIDTH+1) for all num (65 at WIDTH=8).
REQ-025 Undefined: early-exit behaviour of REQ-017/018; results identical in both modes.

Structure
REQ-026 Package prime_pkg SHALL hold the FSM state enum and the localparam functions for d width and constant-time iteration count.
REQ-027 Sub-module seq_mod SHALL implement the WIDTH-cycle remainder (ports clk, rst_n, go, dividend, divisor, done, rem).

Verification
REQ-028 WIDTH=8, variable, start with num=7 -> finish at T+2, is_prime=1, factor=0.
REQ-029 num=9 -> finish at T+11, is_prime=0, factor=3; num=221 -> factor=13, is_prime=0.
REQ-030 num=0,1,2,4 -> (0,0),(0,0),(1,0),(0,2) as (is_prime,factor), each finish at T+2.
REQ-031 CONST_TIME_EN, WIDTH=8: num=7, 9, 251, 15 -> finish always at T+65; 15 gives factor 3, not 15.
REQ-032 rst_n low for 1 cycle during DIV of num=221 -> outputs 0 immediately, no finish afterwards; new start num=13 -> is_prime=1.
REQ-033 start pulsed while busy with num=4 -> ignored, original result unchanged.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared types and sizing helpers for the prime tester.
// No logic: FSM state encoding, trial-divisor width, constant-time trip count.
// No flow control here; consumers size their datapaths from these functions.
package prime_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_DIV   = 3'd2,
      S_NEXT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Trial divisor width: one bit above half the candidate width, so the
   // divisor following the last useful one still fits.
   function automatic int d_width(input int width);
      return width / 2 + 1;
   endfunction

   // Number of odd divisors 3, 5, ... 2^(width/2)-1 swept in constant-time mode.
   function automatic int ct_iters(input int width);
      return (1 << (width / 2 - 1)) - 1;
   endfunction

endpackage

// File: rtl/seq_mod.sv
// Sequential restoring remainder: rem = dividend mod divisor.
// Latency: WIDTH cycles after the go edge; done is high in the cycle whose edge performs the last step.
// No backpressure: go restarts unconditionally; divisor must stay stable while running.
// Ports: clk, rst_n (async, active-low), go (load pulse), dividend, divisor, done, rem.
module seq_mod
   import prime_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DW    = d_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             go,
   input  logic [WIDTH-1:0] dividend,
   input  logic [DW-1:0]    divisor,
   output logic             done,
   output logic [WIDTH-1:0] rem
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] r_nxt;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   shifted;
   logic [CW-1:0]    cnt;

   // One restoring step: bring in the next dividend bit, subtract if it fits.
   // The true result is below the divisor, so a WIDTH-bit subtract is exact.
   always_comb begin
      dvs     = WIDTH'(divisor);
      shifted = {r, q[WIDTH-1]};
      r_nxt   = shifted[WIDTH-1:0];
      if (shifted >= {1'b0, dvs}) begin
         r_nxt = shifted[WIDTH-1:0] - dvs;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= '0;
         r   <= '0;
         cnt <= '0;
      end else if (go) begin
         q   <= dividend;
         r   <= '0;
         cnt <= CW'(WIDTH);
      end else if (cnt != '0) begin
         q   <= {q[WIDTH-2:0], 1'b0};
         r   <= r_nxt;
         cnt <= cnt - CW'(1);
      end
   end

   assign done = (cnt == CW'(1));
   assign rem  = r;

endmodule

// File: rtl/prime_tester.sv
// Trial-division primality tester reporting the smallest nontrivial factor.
// Latency: 2 cycles for trivial cases, else 2 + k*(WIDTH+1); fixed 2 + ct_iters*(WIDTH+1) with PRIME_TESTER_CONST_TIME_EN.
// No backpressure: start is only sampled in IDLE/DONE and ignored while busy.
// Ports: clk, rst_n (async, active-low), start/num request, busy, finish (DONE pulse), is_prime, factor.
// Build option: define PRIME_TESTER_CONST_TIME_EN for data-independent latency.
module prime_tester
   import prime_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] num,
   output logic             busy,
   output logic             finish,
   output logic             is_prime,
   output logic [WIDTH-1:0] factor
);

   localparam int DW = d_width(WIDTH);
`ifdef PRIME_TESTER_CONST_TIME_EN
   localparam logic [DW-1:0] D_MAX = DW'(2 * ct_iters(WIDTH) + 1);
`endif

   state_t           state, state_nxt;
   logic [WIDTH-1:0] num_q;
   logic [DW-1:0]    d, d_nxt, d_step;
   logic [WIDTH+1:0] dsq, dsq_nxt, dsq_step;
   logic [WIDTH-1:0] fac_nxt;
   logic [WIDTH-1:0] rem;
   logic             go, accept, div_done, prime_nxt;

   seq_mod #(.WIDTH(WIDTH), .DW(DW)) u_mod (
      .clk      (clk),
      .rst_n    (rst_n),
      .go       (go),
      .dividend (num_q),
      .divisor  (d),
      .done     (div_done),
      .rem      (rem)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      go        = 1'b0;
      accept    = 1'b0;
      d_nxt     = d;
      dsq_nxt   = dsq;
      fac_nxt   = factor;
      prime_nxt = is_prime;
      // (d+2)^2 = d^2 + 4d + 4 keeps the square without a multiplier.
      d_step    = d + DW'(2);
      dsq_step  = dsq + (WIDTH+2)'({d, 2'b00}) + (WIDTH+2)'(4);
      case (state)
         S_IDLE, S_DONE: begin
            state_nxt = S_IDLE;
            if (start) begin
               state_nxt = S_CHECK;
               accept    = 1'b1;
               d_nxt     = DW'(3);
               dsq_nxt   = (WIDTH+2)'(9);
               fac_nxt   = '0;
               prime_nxt = 1'b0;
            end
         end
         S_CHECK: begin
            if (!num_q[0] && num_q > WIDTH'(2)) fac_nxt = WIDTH'(2);
`ifdef PRIME_TESTER_CONST_TIME_EN
            state_nxt = S_DIV;
            go        = 1'b1;
`else
            // Below 9 no odd divisor can have d*d <= num.
            if (!num_q[0] || num_q < WIDTH'(9)) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_DIV;
               go        = 1'b1;
            end
`endif
         end
         S_DIV: begin
            if (div_done) state_nxt = S_NEXT;
         end
         S_NEXT: begin
            // The d*d gate keeps num itself (or a cofactor) from being reported.
            if (rem == '0 && dsq <= {2'b00, num_q} && factor == '0) fac_nxt = WIDTH'(d);
            d_nxt   = d_step;
            dsq_nxt = dsq_step;
`ifdef PRIME_TESTER_CONST_TIME_EN
            if (d == D_MAX) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_DIV;
               go        = 1'b1;
            end
`else
            if (fac_nxt != '0 || dsq_step > {2'b00, num_q}) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_DIV;
               go        = 1'b1;
            end
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
      if (state_nxt == S_DONE) prime_nxt = (fac_nxt == '0) && (num_q >= WIDTH'(2));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_q    <= '0;
         d        <= '0;
         dsq      <= '0;
         factor   <= '0;
         is_prime <= 1'b0;
      end else begin
         if (accept) num_q <= num;
         d        <= d_nxt;
         dsq      <= dsq_nxt;
         factor   <= fac_nxt;
         is_prime <= prime_nxt;
      end
   end

   assign busy   = (state != S_IDLE) && (state != S_DONE);
   assign finish = (state == S_DONE);

endmodule
